// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, reset PC default, NOP word and small address helpers.
package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_VALID = 3'd2,
        ST_EXEC  = 3'd3,
        ST_ERR   = 3'd4
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:2] addr_hi);
        return {addr_hi, 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit bus bundle: instruction memory port, decode handoff and next-PC commit.
// master = fetch unit side, slave = memory / pipeline side.
interface ifu_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic        fetch_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst,
        output pc,
        input  next_pc_valid,
        input  next_pc,
        output fetch_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  pc,
        output next_pc_valid,
        output next_pc,
        input  fetch_err
    );

endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit with a zero-bubble next-PC path.
// Optional macro IFU_MISALIGN_CHECK_EN traps misaligned next-PC loads into ST_ERR.
//
// state    | meaning
// ST_REQ   | imem_req high, waiting for imem_gnt
// ST_WAIT  | request accepted, waiting for imem_rvalid
// ST_VALID | inst/pc presented to decode, waiting for inst_ready
// ST_EXEC  | inst consumed, waiting for execute to commit next PC
// ST_ERR   | misaligned next PC trapped; held until rst
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);

    ifu_state_e  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_imem_req;
    logic        r_inst_valid;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        r_fetch_err;
`endif

    logic w_handshake;
    logic w_load_pc;
    logic w_to_err;

    // r_inst_valid is high exactly in ST_VALID, so the state alone qualifies the handshake
    assign w_handshake = (r_state == ST_VALID) && bus.inst_ready;
    assign w_load_pc   = bus.next_pc_valid && (w_handshake || (r_state == ST_EXEC));

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_to_err = is_misaligned(bus.next_pc[1:0]);
`else
    assign w_to_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= IFU_NOP;
            r_imem_req   <= 1'b1;
            r_inst_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            r_fetch_err  <= 1'b0;
`endif
        end else begin
            if (w_load_pc) begin
                r_pc <= bus.next_pc;
            end

            case (r_state)
                ST_REQ: begin
                    if (bus.imem_gnt) begin
                        r_imem_req <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_inst       <= bus.imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_state      <= ST_VALID;
                    end
                end

                ST_VALID, ST_EXEC: begin
                    if (w_handshake) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= ST_EXEC;
                    end
                    // Later assignment wins: a load in the handshake cycle skips ST_EXEC
                    if (w_load_pc) begin
                        if (w_to_err) begin
                            r_state     <= ST_ERR;
`ifdef IFU_MISALIGN_CHECK_EN
                            r_fetch_err <= 1'b1;
`endif
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= ST_REQ;
                        end
                    end
                end

                ST_ERR: begin
`ifndef IFU_MISALIGN_CHECK_EN
                    r_imem_req <= 1'b1;
                    r_state    <= ST_REQ;
`endif
                end

                default: begin
                    r_imem_req   <= 1'b1;
                    r_inst_valid <= 1'b0;
                    r_state      <= ST_REQ;
                end
            endcase
        end
    end

    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = word_align(r_pc[31:2]);
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.pc         = r_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    assign bus.fetch_err  = r_fetch_err;
`else
    assign bus.fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: scoreboard of {inst, pc} pairs pushed when
// read data is returned and popped when decode accepts the pair.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(32'h8000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb[$];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic after_load(input logic [31:0] npc);
`ifdef IFU_MISALIGN_CHECK_EN
        if (npc[1:0] != 2'b00) begin
            chk("err_flag", bus.fetch_err, 1'b1);
            chk("err_req", bus.imem_req, 1'b0);
            chk("err_valid", bus.inst_valid, 1'b0);
            return;
        end
`endif
        chk("load_req", bus.imem_req, 1'b1);
        chk("load_addr", bus.imem_addr, {npc[31:2], 2'b00});
        chk("load_pc", bus.pc, npc);
        chk("load_err", bus.fetch_err, 1'b0);
        chk("load_valid", bus.inst_valid, 1'b0);
    endtask

    task automatic fetch(input int gnt_dly, input int wait_dly, input logic [31:0] data);
        for (int i = 0; i < gnt_dly; i++) begin
            bus.imem_rvalid = (i == 0);
            bus.imem_rdata  = 32'hDEAD_BEEF;
            tick();
            bus.imem_rvalid = 1'b0;
            chk("req_hold", bus.imem_req, 1'b1);
            chk("addr_stable", bus.imem_addr, {m_pc[31:2], 2'b00});
            chk("req_no_valid", bus.inst_valid, 1'b0);
        end
        chk("addr_at_gnt", bus.imem_addr, {m_pc[31:2], 2'b00});
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        chk("req_drop", bus.imem_req, 1'b0);
        for (int i = 0; i < wait_dly; i++) begin
            bus.next_pc_valid = 1'b1;
            bus.next_pc       = 32'h8000_1000;
            tick();
            bus.next_pc_valid = 1'b0;
            chk("wait_pc", bus.pc, m_pc);
            chk("wait_valid", bus.inst_valid, 1'b0);
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        sb.push_back({data, m_pc});
        tick();
        bus.imem_rvalid = 1'b0;
        chk("valid_latency", bus.inst_valid, 1'b1);
    endtask

    task automatic consume(input int stall, input logic same, input logic [31:0] npc);
        logic [63:0] exp;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        exp = sb[0];
        for (int k = 0; k < stall; k++) begin
            bus.inst_ready    = 1'b0;
            bus.next_pc_valid = (k == 0);
            bus.next_pc       = 32'h8000_2000;
            tick();
            bus.next_pc_valid = 1'b0;
            chk("stall_inst", bus.inst, exp[63:32]);
            chk("stall_pc", bus.pc, exp[31:0]);
            chk("stall_valid", bus.inst_valid, 1'b1);
        end
        exp = sb.pop_front();
        chk("inst", bus.inst, exp[63:32]);
        chk("pc", bus.pc, exp[31:0]);
        bus.inst_ready    = 1'b1;
        bus.next_pc_valid = same;
        bus.next_pc       = npc;
        tick();
        bus.inst_ready    = 1'b0;
        bus.next_pc_valid = 1'b0;
        if (!same) begin
            chk("exec_valid", bus.inst_valid, 1'b0);
            chk("exec_req", bus.imem_req, 1'b0);
            tick();
            chk("exec_idle_req", bus.imem_req, 1'b0);
            chk("exec_idle_pc", bus.pc, m_pc);
            bus.next_pc_valid = 1'b1;
            bus.next_pc       = npc;
            tick();
            bus.next_pc_valid = 1'b0;
        end
        m_pc = npc;
        after_load(npc);
    endtask

    initial begin
        bus.imem_gnt      = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.inst_ready    = 1'b0;
        bus.next_pc_valid = 1'b0;
        bus.next_pc       = 32'h0;
        m_pc              = 32'h8000_0000;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.inst_valid, 1'b0);
        chk("rst_pc", bus.pc, 32'h8000_0000);
        chk("rst_inst", bus.inst, 32'h0000_0013);
        chk("rst_err", bus.fetch_err, 1'b0);
        rst = 1'b0;
        tick();
        chk("rel_req", bus.imem_req, 1'b1);
        chk("rel_addr", bus.imem_addr, 32'h8000_0000);

        fetch(0, 0, 32'h0010_0093);
        consume(3, 1'b1, 32'h8000_0004);

        fetch(5, 0, 32'h0020_0113);
        consume(0, 1'b0, 32'h8000_0008);

        fetch(0, 2, 32'h0030_0193);
        consume(1, 1'b1, 32'h8000_0006);

`ifdef IFU_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            bus.imem_gnt = 1'b1;
            tick();
            chk("err_hold", bus.fetch_err, 1'b1);
            chk("err_hold_req", bus.imem_req, 1'b0);
        end
        bus.imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        m_pc = 32'h8000_0000;
        chk("err_clear", bus.fetch_err, 1'b0);
`else
        fetch(0, 0, 32'h0040_0213);
        consume(0, 1'b1, 32'h8000_000C);
`endif

        for (int n = 0; n < 6; n++) begin
            fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
            consume(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), m_pc + 32'd4);
        end

        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        chk("pre_rst_wait", bus.imem_req, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        m_pc = 32'h8000_0000;
        chk("wait_rst_pc", bus.pc, 32'h8000_0000);
        chk("wait_rst_valid", bus.inst_valid, 1'b0);
        chk("wait_rst_inst", bus.inst, 32'h0000_0013);
        chk("wait_rst_req", bus.imem_req, 1'b1);

        fetch(1, 0, 32'h0050_0293);
        consume(0, 1'b1, 32'h8000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
